shift_param_bank: RTL and testbench

- Parametrised, writable successor to the fixed per-layer shift ROMs: one banked store holds requantisation shift bytes for LAYERS layers × CH channels.
- Sits between the RISC-V SoC config bus (load path) and the CNN engine requant stage (read path).
- Read modes: single-cycle-latency random lookup, and a valid/ready channel stream that walks one layer's channels in order.

---
 rtl/shift_param_bank.sv | 179 +++++++++++++++++
 tb/tb_shift_param_bank.sv | 430 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/shift_param_bank.sv
// Banked store of per-layer, per-channel requantisation shift bytes.
// Config-bus write port, single-cycle random lookup port, and a valid/ready
// stream that walks one layer's channels in order.
module shift_param_bank #(
  parameter int unsigned DATA_W    = 8,
  parameter int unsigned CH        = 64,
  parameter int unsigned LAYERS    = 4,
  parameter int unsigned CH_W      = $clog2(CH),
  parameter int unsigned LAYER_W   = (LAYERS > 1) ? $clog2(LAYERS) : 1,
  parameter string       INIT_FILE = ""
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cfg_we,
  input  logic [LAYER_W-1:0] cfg_layer,
  input  logic [CH_W-1:0]    cfg_addr,
  input  logic [DATA_W-1:0]  cfg_wdata,
  output logic               cfg_err,
  input  logic               rd_req,
  input  logic [LAYER_W-1:0] rd_layer,
  input  logic [CH_W-1:0]    rd_addr,
  output logic               rd_valid,
  output logic [DATA_W-1:0]  rd_data,
  input  logic               st_start,
  input  logic [LAYER_W-1:0] st_layer,
  input  logic [CH_W:0]      st_count,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [DATA_W-1:0]  out_data,
  output logic [CH_W-1:0]    out_ch,
  output logic               out_last,
  output logic               busy
);

  localparam int unsigned DEPTH = LAYERS * CH;
  localparam int unsigned IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {IDLE, STREAM, DRAIN} state_t;

  logic [DATA_W-1:0] mem [DEPTH];

  state_t             state_q, state_d;
  logic [LAYER_W-1:0] layer_q, layer_d;
  logic [CH_W:0]      count_q, count_d;
  logic [CH_W-1:0]    ptr_q, ptr_d;
  logic               out_valid_q, out_valid_d;
  logic [DATA_W-1:0]  out_data_q, out_data_d;
  logic [CH_W-1:0]    out_ch_q, out_ch_d;
  logic               out_last_q, out_last_d;
  logic               busy_q, busy_d;
  logic               rd_valid_q, rd_valid_d;
  logic [DATA_W-1:0]  rd_data_q, rd_data_d;
  logic               cfg_err_q, cfg_err_d;

  logic wr_ok_c;
  logic last_c;

  function automatic logic [IDX_W-1:0] flat_idx(input logic [LAYER_W-1:0] l,
                                                input logic [CH_W-1:0]    c);
    return IDX_W'(l) * IDX_W'(CH) + IDX_W'(c);
  endfunction

  // Zero-extended compare keeps the check meaningful for non-power-of-2 sizes
  function automatic logic layer_ok(input logic [LAYER_W-1:0] l);
    return {1'b0, l} < (LAYER_W+1)'(LAYERS);
  endfunction

  function automatic logic ch_ok(input logic [CH_W-1:0] c);
    return {1'b0, c} < (CH_W+1)'(CH);
  endfunction

  // Writes must not touch the layer currently being streamed
  assign wr_ok_c = cfg_we && layer_ok(cfg_layer) && ch_ok(cfg_addr) &&
                   !((state_q != IDLE) && (cfg_layer == layer_q));

  assign last_c = ({1'b0, ptr_q} == (count_q - (CH_W+1)'(1)));

  // Synchronous write port; contents are never reset
  always_ff @(posedge clk) begin
    if (wr_ok_c) begin
      mem[flat_idx(cfg_layer, cfg_addr)] <= cfg_wdata;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d     = state_q;
    layer_d     = layer_q;
    count_d     = count_q;
    ptr_d       = ptr_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_ch_d    = out_ch_q;
    out_last_d  = out_last_q;
    rd_valid_d  = 1'b0;
    rd_data_d   = rd_data_q;
    cfg_err_d   = cfg_we && !wr_ok_c;

    unique case (state_q)
      IDLE: begin
        if (st_start) begin
          if ((st_count != '0) && (st_count <= (CH_W+1)'(CH))) begin
            state_d = STREAM;
            layer_d = st_layer;
            count_d = st_count;
            ptr_d   = '0;
          end
        end else if (rd_req) begin
          rd_valid_d = 1'b1;
          rd_data_d  = (layer_ok(rd_layer) && ch_ok(rd_addr)) ?
                       mem[flat_idx(rd_layer, rd_addr)] : '0;
        end
      end
      STREAM: begin
        if (!out_valid_q || out_ready) begin
          out_valid_d = 1'b1;
          out_data_d  = layer_ok(layer_q) ? mem[flat_idx(layer_q, ptr_q)] : '0;
          out_ch_d    = ptr_q;
          out_last_d  = last_c;
          ptr_d       = ptr_q + CH_W'(1);
          if (last_c) begin
            state_d = DRAIN;
          end
        end
      end
      DRAIN: begin
        if (out_valid_q && out_ready) begin
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    busy_d = (state_d != IDLE);
  end

  // State and output registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      layer_q     <= '0;
      count_q     <= '0;
      ptr_q       <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_ch_q    <= '0;
      out_last_q  <= 1'b0;
      busy_q      <= 1'b0;
      rd_valid_q  <= 1'b0;
      rd_data_q   <= '0;
      cfg_err_q   <= 1'b0;
    end else begin
      state_q     <= state_d;
      layer_q     <= layer_d;
      count_q     <= count_d;
      ptr_q       <= ptr_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_ch_q    <= out_ch_d;
      out_last_q  <= out_last_d;
      busy_q      <= busy_d;
      rd_valid_q  <= rd_valid_d;
      rd_data_q   <= rd_data_d;
      cfg_err_q   <= cfg_err_d;
    end
  end

  assign cfg_err   = cfg_err_q;
  assign rd_valid  = rd_valid_q;
  assign rd_data   = rd_data_q;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_ch    = out_ch_q;
  assign out_last  = out_last_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_shift_param_bank.sv
// Scoreboard bench for shift_param_bank: expected lookups and stream beats
// are queued from a local memory model when stimulus is driven.
module tb_shift_param_bank;

  localparam int unsigned DW = 8;
  localparam int unsigned NCH = 64;
  localparam int unsigned NL = 4;
  localparam int unsigned CW = 6;
  localparam int unsigned LW = 2;

  typedef struct packed {
    logic [DW-1:0] d;
    logic [CW-1:0] ch;
    logic          last;
  } beat_t;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          cfg_we = 1'b0;
  logic [LW-1:0] cfg_layer = '0;
  logic [CW-1:0] cfg_addr = '0;
  logic [DW-1:0] cfg_wdata = '0;
  logic          cfg_err;
  logic          rd_req = 1'b0;
  logic [LW-1:0] rd_layer = '0;
  logic [CW-1:0] rd_addr = '0;
  logic          rd_valid;
  logic [DW-1:0] rd_data;
  logic          st_start = 1'b0;
  logic [LW-1:0] st_layer = '0;
  logic [CW:0]   st_count = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [DW-1:0] out_data;
  logic [CW-1:0] out_ch;
  logic          out_last;
  logic          busy;

  beat_t         exp_q[$];
  logic [DW-1:0] rd_q[$];
  logic [DW-1:0] model [NL][NCH];
  int            n_cmp = 0;
  int            n_bad = 0;

  always #5 clk = ~clk;

  shift_param_bank #(.DATA_W(DW), .CH(NCH), .LAYERS(NL)) dut (
    .clk(clk), .rst(rst),
    .cfg_we(cfg_we), .cfg_layer(cfg_layer), .cfg_addr(cfg_addr),
    .cfg_wdata(cfg_wdata), .cfg_err(cfg_err),
    .rd_req(rd_req), .rd_layer(rd_layer), .rd_addr(rd_addr),
    .rd_valid(rd_valid), .rd_data(rd_data),
    .st_start(st_start), .st_layer(st_layer), .st_count(st_count),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_ch(out_ch), .out_last(out_last), .busy(busy)
  );

  // Queue the expected beats of a stream from the model
  task automatic push_stream(input int layer, input int count);
    beat_t b;
    for (int c = 0; c < count; c++) begin
      b.d    = model[layer][c];
      b.ch   = CW'(c);
      b.last = (c == count - 1);
      exp_q.push_back(b);
    end
  endtask

  task automatic start_stream(input int layer, input int count);
    st_start = 1'b1;
    st_layer = LW'(layer);
    st_count = (CW+1)'(count);
    @(negedge clk);
    st_start = 1'b0;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_cmp++;
    if ({cfg_err, rd_valid, out_valid, out_last, busy} !== 5'b0) begin
      n_bad++;
      $display("FAIL reset_flags: got %b expected 00000",
               {cfg_err, rd_valid, out_valid, out_last, busy});
    end
    n_cmp++;
    if ({rd_data, out_data, out_ch} !== 22'b0) begin
      n_bad++;
      $display("FAIL reset_data: got %h expected 0", {rd_data, out_data, out_ch});
    end
    rst = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL reset_release_busy: got %b expected 0", busy);
    end
  endtask

  task automatic test_load;
    logic [DW-1:0] e;
    int a;
    for (int c = 0; c < NCH; c++) begin
      cfg_we    = 1'b1;
      cfg_layer = 2'd1;
      cfg_addr  = CW'(c);
      cfg_wdata = DW'(c) ^ 8'h5A;
      model[1][c] = DW'(c) ^ 8'h5A;
      @(negedge clk);
      cfg_we = 1'b0;
      n_cmp++;
      if (cfg_err !== 1'b0) begin
        n_bad++;
        $display("FAIL load_cfg_err ch%0d: got %b expected 0", c, cfg_err);
      end
    end
    // Single lookups with fixed expected values
    rd_req = 1'b1; rd_layer = 2'd1; rd_addr = 6'd0;
    @(negedge clk);
    rd_req = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h5A) begin
      n_bad++;
      $display("FAIL rd_1_0: got v=%b d=%h expected v=1 d=5a", rd_valid, rd_data);
    end
    @(negedge clk);
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_pulse_width: got %b expected 0", rd_valid);
    end
    rd_req = 1'b1; rd_layer = 2'd1; rd_addr = 6'd63;
    @(negedge clk);
    rd_req = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h65) begin
      n_bad++;
      $display("FAIL rd_1_63: got v=%b d=%h expected v=1 d=65", rd_valid, rd_data);
    end
    // Back-to-back lookups: one result per cycle
    for (int i = 0; i <= 10; i++) begin
      if (i > 0) begin
        n_cmp++;
        e = (rd_q.size() > 0) ? rd_q.pop_front() : 8'hxx;
        if (rd_valid !== 1'b1 || rd_data !== e) begin
          n_bad++;
          $display("FAIL rd_b2b_%0d: got v=%b d=%h expected v=1 d=%h", i, rd_valid, rd_data, e);
        end
      end
      if (i < 10) begin
        a = $urandom_range(0, NCH - 1);
        rd_req = 1'b1; rd_layer = 2'd1; rd_addr = CW'(a);
        rd_q.push_back(model[1][a]);
      end else begin
        rd_req = 1'b0;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL rd_b2b_end: got %b expected 0", rd_valid);
    end
  endtask

  task automatic test_full_stream;
    beat_t b;
    int first = -1;
    int last = -1;
    out_ready = 1'b1;
    push_stream(1, 64);
    start_stream(1, 64);
    n_cmp++;
    if (busy !== 1'b1 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL full_start: got busy=%b v=%b expected busy=1 v=0", busy, out_valid);
    end
    for (int cyc = 0; cyc < 300 && exp_q.size() > 0; cyc++) begin
      if (out_valid && out_ready) begin
        b = exp_q.pop_front();
        n_cmp++;
        if ({out_data, out_ch, out_last} !== b) begin
          n_bad++;
          $display("FAIL full_beat: got d=%h ch=%0d l=%b expected d=%h ch=%0d l=%b",
                   out_data, out_ch, out_last, b.d, b.ch, b.last);
        end
        if (first < 0) first = cyc;
        last = cyc;
      end
      @(negedge clk);
    end
    n_cmp++;
    if (exp_q.size() != 0 || last - first != 63) begin
      n_bad++;
      $display("FAIL full_contiguous: got left=%0d span=%0d expected left=0 span=63",
               exp_q.size(), last - first);
    end
    exp_q.delete();
    n_cmp++;
    if (busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL full_end: got busy=%b v=%b expected 0 0", busy, out_valid);
    end
  endtask

  task automatic test_backpressure;
    beat_t b;
    int pat[4] = '{1, 0, 0, 1};
    int hs = 0;
    push_stream(1, 5);
    out_ready = 1'b0;
    start_stream(1, 5);
    for (int cyc = 0; cyc < 100 && hs < 5; cyc++) begin
      out_ready = pat[cyc % 4][0];
      if (out_valid) begin
        b = (exp_q.size() > 0) ? exp_q[0] : 'x;
        n_cmp++;
        if ({out_data, out_ch, out_last} !== b) begin
          n_bad++;
          $display("FAIL bp_beat rdy=%b: got d=%h ch=%0d l=%b expected d=%h ch=%0d l=%b",
                   out_ready, out_data, out_ch, out_last, b.d, b.ch, b.last);
        end
        if (out_ready) begin
          void'(exp_q.pop_front());
          hs++;
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (hs != 5 || exp_q.size() != 0 || busy !== 1'b0 || out_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL bp_end: got hs=%0d left=%0d busy=%b v=%b expected 5 0 0 0",
               hs, exp_q.size(), busy, out_valid);
    end
    exp_q.delete();
  endtask

  task automatic test_conflicts;
    beat_t b;
    out_ready = 1'b0;
    push_stream(1, 64);
    start_stream(1, 64);
    // Write to streaming layer is rejected
    cfg_we = 1'b1; cfg_layer = 2'd1; cfg_addr = 6'd5; cfg_wdata = 8'hEE;
    @(negedge clk);
    cfg_we = 1'b0;
    n_cmp++;
    if (cfg_err !== 1'b1) begin
      n_bad++;
      $display("FAIL conf_err_pulse: got %b expected 1", cfg_err);
    end
    // Write to another layer proceeds
    cfg_we = 1'b1; cfg_layer = 2'd2; cfg_addr = 6'd7; cfg_wdata = 8'h77;
    model[2][7] = 8'h77;
    @(negedge clk);
    cfg_we = 1'b0;
    n_cmp++;
    if (cfg_err !== 1'b0) begin
      n_bad++;
      $display("FAIL conf_other_layer: got %b expected 0", cfg_err);
    end
    // Lookup while busy is ignored
    rd_req = 1'b1; rd_layer = 2'd1; rd_addr = 6'd0;
    @(negedge clk);
    rd_req = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b0) begin
      n_bad++;
      $display("FAIL conf_rd_busy: got %b expected 0", rd_valid);
    end
    // Zero-count start while busy is ignored; first beat held
    start_stream(2, 0);
    b = exp_q[0];
    n_cmp++;
    if (busy !== 1'b1 || out_valid !== 1'b1 || {out_data, out_ch, out_last} !== b) begin
      n_bad++;
      $display("FAIL conf_hold: got busy=%b v=%b ch=%0d expected busy=1 v=1 ch=%0d",
               busy, out_valid, out_ch, b.ch);
    end
    out_ready = 1'b1;
    for (int cyc = 0; cyc < 300 && exp_q.size() > 0; cyc++) begin
      if (out_valid && out_ready) begin
        b = exp_q.pop_front();
        n_cmp++;
        if ({out_data, out_ch, out_last} !== b) begin
          n_bad++;
          $display("FAIL conf_beat: got d=%h ch=%0d l=%b expected d=%h ch=%0d l=%b",
                   out_data, out_ch, out_last, b.d, b.ch, b.last);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL conf_drain: got left=%0d busy=%b expected 0 0", exp_q.size(), busy);
    end
    exp_q.delete();
    // Readback: rejected entry unchanged, other-layer write landed
    rd_req = 1'b1; rd_layer = 2'd1; rd_addr = 6'd5;
    @(negedge clk);
    rd_layer = 2'd2; rd_addr = 6'd7;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h5F) begin
      n_bad++;
      $display("FAIL conf_readback_1_5: got v=%b d=%h expected v=1 d=5f", rd_valid, rd_data);
    end
    @(negedge clk);
    rd_req = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h77) begin
      n_bad++;
      $display("FAIL conf_readback_2_7: got v=%b d=%h expected v=1 d=77", rd_valid, rd_data);
    end
    // Invalid counts in IDLE are ignored
    start_stream(1, 0);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_count0: got busy=%b expected 0", busy);
    end
    start_stream(1, 65);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL idle_count65: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_same_cycle;
    cfg_we = 1'b1; cfg_layer = 2'd0; cfg_addr = 6'd3; cfg_wdata = 8'h11;
    @(negedge clk);
    cfg_wdata = 8'h22;
    rd_req = 1'b1; rd_layer = 2'd0; rd_addr = 6'd3;
    @(negedge clk);
    cfg_we = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h11) begin
      n_bad++;
      $display("FAIL rw_same_old: got v=%b d=%h expected v=1 d=11", rd_valid, rd_data);
    end
    @(negedge clk);
    rd_req = 1'b0;
    n_cmp++;
    if (rd_valid !== 1'b1 || rd_data !== 8'h22) begin
      n_bad++;
      $display("FAIL rw_same_new: got v=%b d=%h expected v=1 d=22", rd_valid, rd_data);
    end
  endtask

  task automatic test_reset_mid;
    beat_t b;
    bit found = 1'b0;
    out_ready = 1'b1;
    push_stream(1, 64);
    start_stream(1, 64);
    for (int cyc = 0; cyc < 100 && !found; cyc++) begin
      if (out_valid && out_ch == 6'd10) begin
        found = 1'b1;
      end else begin
        if (out_valid && out_ready) begin
          b = exp_q.pop_front();
          n_cmp++;
          if ({out_data, out_ch, out_last} !== b) begin
            n_bad++;
            $display("FAIL mid_beat: got d=%h ch=%0d expected d=%h ch=%0d",
                     out_data, out_ch, b.d, b.ch);
          end
        end
        @(negedge clk);
      end
    end
    n_cmp++;
    if (!found) begin
      n_bad++;
      $display("FAIL mid_timeout: got no beat 10 expected beat 10");
    end
    #1 rst = 1'b1;
    #1;
    n_cmp++;
    if (out_valid !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL mid_async: got v=%b busy=%b expected 0 0", out_valid, busy);
    end
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    push_stream(1, 3);
    start_stream(1, 3);
    for (int cyc = 0; cyc < 50 && exp_q.size() > 0; cyc++) begin
      if (out_valid && out_ready) begin
        b = exp_q.pop_front();
        n_cmp++;
        if ({out_data, out_ch, out_last} !== b) begin
          n_bad++;
          $display("FAIL post_reset_beat: got d=%h ch=%0d l=%b expected d=%h ch=%0d l=%b",
                   out_data, out_ch, out_last, b.d, b.ch, b.last);
        end
      end
      @(negedge clk);
    end
    n_cmp++;
    if (exp_q.size() != 0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL post_reset_end: got left=%0d busy=%b expected 0 0", exp_q.size(), busy);
    end
    exp_q.delete();
  endtask

  initial begin
    test_reset();
    test_load();
    test_full_stream();
    test_backpressure();
    test_conflicts();
    test_same_cycle();
    test_reset_mid();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1);
  end

endmodule
